// File: rtl/joy_db15_pkg.sv
// ============================================================================
// joy_db15_pkg : shared types and constants for the DB15 joystick transmitter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package joy_db15_pkg;

    localparam int DEFAULT_FRAME_BITS = 24;
    localparam int DEFAULT_TIMEOUT    = 4096;
    localparam int PLAYER_W           = 12;

    // Button bit positions within one player word (MSB..LSB: L S F E D C B A U D L R)
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_D     = 7;
    localparam int BTN_E     = 8;
    localparam int BTN_F     = 9;
    localparam int BTN_S     = 10;
    localparam int BTN_L     = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// sync_edge : 2-flop synchronizer with registered rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s_meta;
    logic s_sync;
    logic s_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_meta <= RESET_VAL;
            s_sync <= RESET_VAL;
            s_prev <= RESET_VAL;
            rise   <= 1'b0;
        end else begin
            s_meta <= async_in;
            s_sync <= s_meta;
            s_prev <= s_sync;
            rise   <= s_sync & ~s_prev;
        end
    end

    // Level is taken from the edge-detect flop so it lines up with the pulse
    assign level = s_prev;

endmodule

`default_nettype wire

// File: rtl/joy_db15_tx.sv
// ============================================================================
// joy_db15_tx : DB15 joystick serial transmitter (load/shift FSM, shift reg)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PLAYER_W-1:0] joystick1,
    input  logic [PLAYER_W-1:0] joystick2,
    input  logic                JOY_CLK,
    input  logic                JOY_LOAD,
    output logic                JOY_DATA,
    output logic                busy,
    output logic                frame_done
);

    localparam int BW     = $clog2(FRAME_BITS + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int PAIR_W = 2 * PLAYER_W;

    logic clk_lvl, clk_rise, load_lvl, load_rise;

    sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (JOY_CLK),
        .level    (clk_lvl),
        .rise     (clk_rise)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sync_load (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (JOY_LOAD),
        .level    (load_lvl),
        .rise     (load_rise)
    );

    // Level is always high alongside a rise pulse; requiring both keeps the pair coherent
    logic shift_edge;
    assign shift_edge = clk_rise & clk_lvl;

    logic [PAIR_W-1:0]     pads_n;
    logic [FRAME_BITS-1:0] load_word;
    assign pads_n = {~joystick2, ~joystick1};

    generate
        if (FRAME_BITS > PAIR_W) begin : g_pad_ones
            assign load_word = {{(FRAME_BITS - PAIR_W){1'b1}}, pads_n};
        end else begin : g_trim
            assign load_word = pads_n[FRAME_BITS-1:0];
        end
    endgenerate

    state_t                state_q, state_n;
    logic [FRAME_BITS-1:0] sr_q, sr_n;
    logic [BW-1:0]         bitcnt_q, bitcnt_n;
    logic [TW-1:0]         tcnt_q, tcnt_n;
    logic                  done_q, done_n;

    always_comb begin
        state_n  = state_q;
        sr_n     = sr_q;
        bitcnt_n = bitcnt_q;
        tcnt_n   = tcnt_q;
        done_n   = 1'b0;

        if (!load_lvl) begin
            // Load strobe overrides everything, including a coincident shift edge
            state_n  = ST_LOAD;
            sr_n     = load_word;
            bitcnt_n = '0;
            tcnt_n   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_rise) begin
                        state_n  = ST_SHIFT;
                        bitcnt_n = '0;
                        tcnt_n   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (shift_edge) begin
                        sr_n     = {1'b1, sr_q[FRAME_BITS-1:1]};
                        bitcnt_n = bitcnt_q + BW'(1);
                        tcnt_n   = '0;
                        if (bitcnt_q == BW'(FRAME_BITS - 1)) begin
                            state_n  = ST_IDLE;
                            sr_n     = '1;
                            bitcnt_n = '0;
                            done_n   = 1'b1;
                        end
                    end else begin
                        if (tcnt_q != TW'(TIMEOUT)) begin
                            tcnt_n = tcnt_q + TW'(1);
                        end
                        if (tcnt_q == TW'(TIMEOUT - 1)) begin
                            state_n  = ST_IDLE;
                            sr_n     = '1;
                            bitcnt_n = '0;
                        end
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    tcnt_n   = '0;
                    bitcnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '1;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            sr_q     <= sr_n;
            bitcnt_q <= bitcnt_n;
            tcnt_q   <= tcnt_n;
            done_q   <= done_n;
        end
    end

    assign JOY_DATA   = sr_q[0];
    assign busy       = (state_q == ST_SHIFT);
    assign frame_done = done_q;

endmodule

`default_nettype wire

// File: doc/joy_db15_tx.md
JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 Parameter FRAME_BITS, default 24: serial frame length, two 12-bit players.
REQ-002 Parameter TIMEOUT, default 4096: clk cycles in SHIFT without a JOY_CLK edge before the frame is abandoned.
REQ-003 clk  in  1  single system clock, 40-50 MHz; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 joystick1  in  12  player-1 buttons, active-high, bit order LS FEDCBAUDLR (bit0 = R).
REQ-006 joystick2  in  12  player-2 buttons, same bit order.
REQ-007 JOY_CLK  in  1  shift clock from the host reader, asynchronous to clk.
REQ-008 JOY_LOAD  in  1  parallel-load strobe from the host, asynchronous, active-low.
REQ-009 JOY_DATA  out  1  serial data to the host, active-low buttons, idle high.
REQ-010 busy  out  1  high while in SHIFT.
REQ-011 frame_done  out  1  one-clk pulse when a full frame has been shifted.

Function
REQ-012 JOY_CLK and JOY_LOAD SHALL each pass through a 2-flop synchronizer plus one edge-detect flop.
REQ-013 The states SHALL be IDLE, LOAD and SHIFT.
REQ-014 Any state, synced JOY_LOAD low: go to LOAD; every clk, sr[23:0] <= {~joystick2, ~joystick1}; busy=0.
REQ-015 LOAD, synced JOY_LOAD rising edge: go to SHIFT with bitcnt=0 and busy=1; sr holds the last loaded value.
REQ-016 JOY_DATA SHALL equal sr[0] at all times, registered, with no combinational path from inputs.
REQ-017 Serial order SHALL be joystick1[0..11] then joystick2[0..11]; the first bit is valid on JOY_DATA before any JOY_CLK edge.
REQ-018 SHIFT, synced JOY_CLK rising edge: sr <= {1'b1, sr[23:1]}; bitcnt++; timeout counter cleared.
REQ-019 On the FRAME_BITS-th JOY_CLK edge: frame_done=1 for one cycle, busy=0, state goes to IDLE, sr is all ones.
REQ-020 Latency: JOY_DATA SHALL change exactly 3 clk cycles after the synchronizer input sees the JOY_CLK rise.
REQ-021 JOY_CLK edges in IDLE or LOAD SHALL be ignored; JOY_DATA stays at sr[0].
REQ-022 JOY_LOAD low in the same cycle as a JOY_CLK edge: load wins, no shift.
REQ-023 JOY_LOAD low mid-frame: abort to LOAD, no frame_done, bitcnt reset on the next load release.
REQ-024 SHIFT with TIMEOUT cycles and no JOY_CLK edge: go to IDLE, sr all ones, busy=0, no frame_done.
REQ-025 bitcnt SHALL be $clog2(FRAME_BITS+1) wide; the timeout counter SHALL be $clog2(TIMEOUT+1) wide and saturate.

Reset
REQ-026 reset_n low: state=IDLE, sr=all ones, JOY_DATA=1, busy=0, frame_done=0, bitcnt=0, timeout counter=0.
REQ-027 Reset values for the synchronizers: JOY_LOAD chain all 1 (inactive), JOY_CLK chain all 0.
REQ-028 Reset asserted mid-frame: all outputs SHALL reach reset values immediately, without a clock.
REQ-029 After reset release, a frame SHALL start only after a full JOY_LOAD low-high sequence.

Structure
REQ-030 Package joy_db15_pkg SHALL hold the state enum, FRAME_BITS default, player width (12) and button bit-index constants.
REQ-031 Sub-module sync_edge (2-flop synchronizer + rising-edge pulse, reset value as parameter) SHALL be instantiated twice.
REQ-032 The top SHALL hold only the FSM, shift register and counters.

Verification
REQ-033 joystick1=12'h001, joystick2=12'h800, load pulse, then 24 JOY_CLK -> JOY_DATA samples before each edge are 0 then 22 ones then 0; frame_done one pulse after edge 24.
REQ-034 Both players 12'hFFF, full frame, 5 extra JOY_CLK -> 24 zeros, then JOY_DATA=1 for the extra clocks; single frame_done.
REQ-035 Load, 10 clocks, load again (joystick1 changed to 12'h010), 24 clocks -> new frame from bit 0 with the bit-4 low; only one frame_done.
REQ-036 Load, 3 clocks, idle 4096 cycles -> busy falls, JOY_DATA=1, no frame_done; later clocks ignored.
REQ-037 reset_n low at bit 12 -> JOY_DATA=1 and busy=0 asynchronously; clocks without a new load produce no frame_done.
REQ-038 JOY_CLK rise and JOY_LOAD fall in the same sample cycle -> no shift, state LOAD, JOY_DATA = ~joystick1[0].
